// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and load/store (port 1).
// One transaction in flight: capture the winner, issue it to memory, route the response back.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CMD_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid_0,
   input  logic [ADDR_W-1:0] i_addr_0,
   input  logic [CMD_W-1:0]  i_cmd_0,
   input  logic [DATA_W-1:0] i_data_0,
   output logic              o_ready_0,
   output logic              o_res_valid_0,
   output logic [DATA_W-1:0] o_res_data_0,
   input  logic              i_res_ready_0,
   input  logic              i_valid_1,
   input  logic [ADDR_W-1:0] i_addr_1,
   input  logic [CMD_W-1:0]  i_cmd_1,
   input  logic [DATA_W-1:0] i_data_1,
   output logic              o_ready_1,
   output logic              o_res_valid_1,
   output logic [DATA_W-1:0] o_res_data_1,
   input  logic              i_res_ready_1,
   output logic              o_mem_valid,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [CMD_W-1:0]  o_mem_cmd,
   output logic [DATA_W-1:0] o_mem_data,
   input  logic              i_mem_ready,
   input  logic              i_mem_res_valid,
   input  logic [DATA_W-1:0] i_mem_res_data,
   output logic              o_mem_res_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              owner;
   logic [ADDR_W-1:0] addr_q;
   logic [CMD_W-1:0]  cmd_q;
   logic [DATA_W-1:0] data_q;
   logic              grant_0, grant_1, accept;

   // On a tie, the port that did not win last time goes next.
   assign grant_0 = i_valid_0 && (!i_valid_1 || last_grant);
   assign grant_1 = i_valid_1 && (!i_valid_0 || !last_grant);
   assign accept  = (state == IDLE) && (grant_0 || grant_1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         addr_q     <= '0;
         cmd_q      <= '0;
         data_q     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner      <= grant_1;
            last_grant <= grant_1;
            addr_q     <= grant_1 ? i_addr_1 : i_addr_0;
            cmd_q      <= grant_1 ? i_cmd_1  : i_cmd_0;
            data_q     <= grant_1 ? i_data_1 : i_data_0;
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      o_ready_0       = 1'b0;
      o_ready_1       = 1'b0;
      o_mem_valid     = 1'b0;
      o_mem_addr      = '0;
      o_mem_cmd       = '0;
      o_mem_data      = '0;
      o_res_valid_0   = 1'b0;
      o_res_data_0    = '0;
      o_res_valid_1   = 1'b0;
      o_res_data_1    = '0;
      o_mem_res_ready = 1'b0;
      case (state)
         IDLE: begin
            // Held low while reset is asserted so nothing looks accepted.
            o_ready_0 = reset && grant_0;
            o_ready_1 = reset && grant_1;
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: begin
            o_mem_valid = 1'b1;
            o_mem_addr  = addr_q;
            o_mem_cmd   = cmd_q;
            o_mem_data  = data_q;
            if (i_mem_ready) state_nxt = RESP;
         end
         RESP: begin
            if (owner) begin
               o_res_valid_1   = i_mem_res_valid;
               o_res_data_1    = i_mem_res_data;
               o_mem_res_ready = i_res_ready_1;
            end else begin
               o_res_valid_0   = i_mem_res_valid;
               o_res_data_0    = i_mem_res_data;
               o_mem_res_ready = i_res_ready_0;
            end
            if (i_mem_res_valid && o_mem_res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vectors for mem_arbiter: each row drives inputs on the falling edge
// and compares every output before the next rising edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid_0, i_valid_1, i_res_ready_0, i_res_ready_1;
   logic [31:0] i_addr_0, i_addr_1, i_data_0, i_data_1;
   logic [1:0]  i_cmd_0, i_cmd_1;
   logic        o_ready_0, o_ready_1, o_res_valid_0, o_res_valid_1;
   logic [31:0] o_res_data_0, o_res_data_1;
   logic        o_mem_valid, i_mem_ready, i_mem_res_valid, o_mem_res_ready;
   logic [31:0] o_mem_addr, o_mem_data, i_mem_res_data;
   logic [1:0]  o_mem_cmd;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CMD_W(2)) dut (
      .clk(clk), .reset(reset),
      .i_valid_0(i_valid_0), .i_addr_0(i_addr_0), .i_cmd_0(i_cmd_0), .i_data_0(i_data_0),
      .o_ready_0(o_ready_0), .o_res_valid_0(o_res_valid_0), .o_res_data_0(o_res_data_0),
      .i_res_ready_0(i_res_ready_0),
      .i_valid_1(i_valid_1), .i_addr_1(i_addr_1), .i_cmd_1(i_cmd_1), .i_data_1(i_data_1),
      .o_ready_1(o_ready_1), .o_res_valid_1(o_res_valid_1), .o_res_data_1(o_res_data_1),
      .i_res_ready_1(i_res_ready_1),
      .o_mem_valid(o_mem_valid), .o_mem_addr(o_mem_addr), .o_mem_cmd(o_mem_cmd),
      .o_mem_data(o_mem_data), .i_mem_ready(i_mem_ready), .i_mem_res_valid(i_mem_res_valid),
      .i_mem_res_data(i_mem_res_data), .o_mem_res_ready(o_mem_res_ready)
   );

   // Inputs first, then expected outputs; cmd 1 = read, 2 = write.
   typedef struct {
      logic [31:0] v0, a0, c0, d0, rr0, v1, a1, c1, d1, rr1, mr, mrv, mrd;
      logic [31:0] r0, r1, mv, ma, mc, md, rv0, rd0, rv1, rd1, mrr;
   } vec_t;

   vec_t tbl[29];
   vec_t rs[7];
   vec_t rst_v;

   task automatic drive(input vec_t v);
      i_valid_0 = v.v0[0]; i_addr_0 = v.a0; i_cmd_0 = v.c0[1:0]; i_data_0 = v.d0;
      i_res_ready_0 = v.rr0[0];
      i_valid_1 = v.v1[0]; i_addr_1 = v.a1; i_cmd_1 = v.c1[1:0]; i_data_1 = v.d1;
      i_res_ready_1 = v.rr1[0];
      i_mem_ready = v.mr[0]; i_mem_res_valid = v.mrv[0]; i_mem_res_data = v.mrd;
   endtask

   task automatic check(input vec_t v, input string nm);
      logic [135:0] act, exp;
      exp = {v.r0[0], v.r1[0], v.mv[0], v.ma, v.mc[1:0], v.md,
             v.rv0[0], v.rd0, v.rv1[0], v.rd1, v.mrr[0]};
      act = {o_ready_0, o_ready_1, o_mem_valid, o_mem_addr, o_mem_cmd, o_mem_data,
             o_res_valid_0, o_res_data_0, o_res_valid_1, o_res_data_1, o_mem_res_ready};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string nm);
      @(negedge clk);
      drive(v);
      #1 check(v, nm);
   endtask

   initial begin
      // both ports valid, held: round-robin 0x100, 0x200, 0x100
      tbl[0]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  1,0,0,0,0,0,0,0,0,0,0};
      tbl[1]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  0,0,1,'h100,1,0,0,0,0,0,0};
      tbl[2]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  0,0,0,0,0,0,1,'hA0,0,0,1};
      tbl[3]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  0,1,0,0,0,0,0,0,0,0,0};
      tbl[4]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  0,0,1,'h200,1,0,0,0,0,0,0};
      tbl[5]  = '{1,'h100,1,0,1, 1,'h200,1,0,1, 1,1,'hA0,  0,0,0,0,0,0,0,0,1,'hA0,1};
      tbl[6]  = tbl[0];
      tbl[7]  = tbl[1];
      tbl[8]  = tbl[2];
      tbl[9]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,  0,0,0,0,0,0,0,0,0,0,0};
      // port0 read 0x10, response 0xDEADBEEF
      tbl[10] = '{1,'h10,1,0,0, 0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0,0,0};
      tbl[11] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h10,1,0,0,0,0,0,0};
      tbl[12] = '{0,0,0,0,1, 0,0,0,0,0, 0,1,'hDEADBEEF,  0,0,0,0,0,0,1,'hDEADBEEF,0,0,1};
      // stray memory response while idle
      tbl[13] = '{0,0,0,0,1, 0,0,0,0,1, 0,1,'h55,  0,0,0,0,0,0,0,0,0,0,0};
      // memory stalls 3 cycles; port0 waits meanwhile
      tbl[14] = '{0,0,0,0,0, 1,'h300,1,0,0, 0,0,0,  0,1,0,0,0,0,0,0,0,0,0};
      tbl[15] = '{1,'h20,1,0,0, 0,0,0,0,0, 0,0,0,  0,0,1,'h300,1,0,0,0,0,0,0};
      tbl[16] = tbl[15];
      tbl[17] = tbl[15];
      tbl[18] = '{1,'h20,1,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h300,1,0,0,0,0,0,0};
      tbl[19] = '{1,'h20,1,0,0, 0,0,0,0,1, 0,1,'h77,  0,0,0,0,0,0,0,0,1,'h77,1};
      tbl[20] = '{1,'h20,1,0,0, 0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0,0,0};
      tbl[21] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h20,1,0,0,0,0,0,0};
      tbl[22] = '{0,0,0,0,1, 0,0,0,0,0, 0,1,'h88,  0,0,0,0,0,0,1,'h88,0,0,1};
      // port1 write, response back-pressured 2 cycles
      tbl[23] = '{0,0,0,0,0, 1,'h44,2,'h1234,0, 0,0,0,  0,1,0,0,0,0,0,0,0,0,0};
      tbl[24] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h44,2,'h1234,0,0,0,0,0};
      tbl[25] = '{0,0,0,0,0, 0,0,0,0,0, 0,1,'hCAFE,  0,0,0,0,0,0,0,0,1,'hCAFE,0};
      tbl[26] = tbl[25];
      tbl[27] = '{0,0,0,0,0, 0,0,0,0,1, 0,1,'hCAFE,  0,0,0,0,0,0,0,0,1,'hCAFE,1};
      tbl[28] = tbl[9];

      // reset mid-RESP, then a clean port0 read to 0x8
      rs[0] = '{1,'h40,1,0,0, 0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0,0,0};
      rs[1] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h40,1,0,0,0,0,0,0};
      rs[2] = '{0,0,0,0,0, 0,0,0,0,0, 0,1,'h99,  0,0,0,0,0,0,1,'h99,0,0,0};
      rs[3] = '{1,'h8,1,0,0, 0,0,0,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0,0,0};
      rs[4] = '{0,0,0,0,0, 0,0,0,0,0, 1,0,0,  0,0,1,'h8,1,0,0,0,0,0,0};
      rs[5] = '{0,0,0,0,1, 0,0,0,0,0, 0,1,'h1357,  0,0,0,0,0,0,1,'h1357,0,0,1};
      rs[6] = tbl[9];
      rst_v = '{1,'h8,1,0,1, 1,'h9,1,0,1, 1,1,'h99,  0,0,0,0,0,0,0,0,0,0,0};

      // reset state: everything low even with requests pending
      reset = 1'b0;
      drive(rst_v);
      #2 check(rst_v, "reset_state");
      drive(tbl[9]);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 29; i++) step(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 3; i++) step(rs[i], $sformatf("pre_rst%0d", i));
      #1 reset = 1'b0;
      drive(rst_v);
      #1 check(rst_v, "rst_mid_resp");
      @(negedge clk);
      #1 check(rst_v, "rst_held");
      drive(tbl[9]);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 3; i < 7; i++) step(rs[i], $sformatf("post_rst%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
